// File: rtl/panel_pkg.sv
// Shared types and constants for the front-panel command unit.
// Optional auto-repeat is enabled by defining PANEL_AUTOREPEAT_EN.
package panel_pkg;

    localparam int PANEL_SW_W = 16;
    localparam int PANEL_PB_W = 5;

    localparam int PB_LOAD = 0;
    localparam int PB_ADD  = 1;
    localparam int PB_SUB  = 2;
    localparam int PB_CLR  = 3;
    localparam int PB_NEG  = 4;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_LOAD = 3'd1,
        CMD_ADD  = 3'd2,
        CMD_SUB  = 3'd3,
        CMD_CLR  = 3'd4,
        CMD_NEG  = 3'd5
    } cmd_e;

    // Keep only the lowest set bit: lowest button index wins.
    function automatic logic [PANEL_PB_W-1:0] lowest_one(
        input logic [PANEL_PB_W-1:0] v
    );
        return v & (~v + PANEL_PB_W'(1));
    endfunction

endpackage

// File: rtl/panel_command_unit_if.sv
// Frame input and display output bundle of the panel command unit.
// Shared by both builds (with or without PANEL_AUTOREPEAT_EN).
interface panel_command_unit_if;
    import panel_pkg::*;

    logic                  frame_stb;
    logic [PANEL_SW_W-1:0] sw;
    logic [PANEL_PB_W-1:0] pb;
    logic [PANEL_SW_W-1:0] acc;
    logic                  carry;
    logic [2:0]            op_code;
    logic                  op_done;
    logic [PANEL_PB_W-1:0] pb_stable;

    modport master (
        output frame_stb, sw, pb,
        input  acc, carry, op_code, op_done, pb_stable
    );

    modport slave (
        input  frame_stb, sw, pb,
        output acc, carry, op_code, op_done, pb_stable
    );

endinterface

// File: rtl/panel_debounce.sv
// One button: frame-counting debouncer with a registered press flag.
// Unaffected by PANEL_AUTOREPEAT_EN.
module panel_debounce #(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_stb,
    input  logic raw,
    output logic stable,
    output logic press
);

    logic [3:0] cnt_q, cnt_d;
    logic       stable_q, stable_d;
    logic       press_q, press_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (frame_stb) begin
            if (raw == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == 4'(DEBOUNCE_FRAMES - 1)) begin
                stable_d = raw;
                cnt_d    = '0;
                press_d  = raw;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/panel_command_unit.sv
// Debounced front-panel buttons executing commands on a 16-bit accumulator.
// Define PANEL_AUTOREPEAT_EN to build ADD/SUB auto-repeat.
module panel_command_unit
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    panel_command_unit_if.slave bus
);

`ifdef PANEL_AUTOREPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic [PANEL_PB_W-1:0] stable_vec, press_vec, rpt_evt, evt, sel;
    logic [PANEL_SW_W-1:0] sw_q, sw_d, acc_q, acc_d;
    logic                  carry_q, carry_d;
    logic                  op_done_q, op_done_d;
    cmd_e                  op_q, op_d;
    logic [PANEL_SW_W:0]   sum, dif;

    for (genvar i = 0; i < PANEL_PB_W; i++) begin : g_db
        panel_debounce #(
            .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
        ) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .frame_stb(bus.frame_stb),
            .raw      (bus.pb[i]),
            .stable   (stable_vec[i]),
            .press    (press_vec[i])
        );
    end

    if (RPT_EN) begin : g_rpt
        logic [1:0][7:0] rcnt_q, rcnt_d;
        logic [1:0]      rfire_q, rfire_d;

        // Counts frames seen while already stable; the press frame starts at 0.
        always_comb begin
            rcnt_d  = rcnt_q;
            rfire_d = '0;
            for (int j = 0; j < 2; j++) begin
                if (bus.frame_stb) begin
                    if (!stable_vec[PB_ADD+j]) begin
                        rcnt_d[j] = '0;
                    end else if (rcnt_q[j] == 8'(REPEAT_FRAMES - 1)) begin
                        rcnt_d[j]  = '0;
                        rfire_d[j] = 1'b1;
                    end else begin
                        rcnt_d[j] = rcnt_q[j] + 8'd1;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rcnt_q  <= '0;
                rfire_q <= '0;
            end else begin
                rcnt_q  <= rcnt_d;
                rfire_q <= rfire_d;
            end
        end

        // A repeat coinciding with the release frame is suppressed here.
        always_comb begin
            rpt_evt         = '0;
            rpt_evt[PB_ADD] = rfire_q[0] & stable_vec[PB_ADD];
            rpt_evt[PB_SUB] = rfire_q[1] & stable_vec[PB_SUB];
        end
    end else begin : g_no_rpt
        assign rpt_evt = '0;
    end

    assign evt = press_vec | rpt_evt;
    assign sel = lowest_one(evt);
    assign sum = {1'b0, acc_q} + {1'b0, sw_q};
    assign dif = {1'b0, acc_q} - {1'b0, sw_q};

    always_comb begin
        sw_d      = bus.frame_stb ? bus.sw : sw_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        op_d      = op_q;
        op_done_d = |evt;
        unique case (1'b1)
            sel[PB_LOAD]: begin
                acc_d   = sw_q;
                carry_d = 1'b0;
                op_d    = CMD_LOAD;
            end
            sel[PB_ADD]: begin
                {carry_d, acc_d} = sum;
                op_d             = CMD_ADD;
            end
            sel[PB_SUB]: begin
                {carry_d, acc_d} = dif;
                op_d             = CMD_SUB;
            end
            sel[PB_CLR]: begin
                acc_d   = '0;
                carry_d = 1'b0;
                op_d    = CMD_CLR;
            end
            sel[PB_NEG]: begin
                acc_d = ~acc_q + PANEL_SW_W'(1);
                op_d  = CMD_NEG;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q      <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            op_q      <= CMD_NONE;
            op_done_q <= 1'b0;
        end else begin
            sw_q      <= sw_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            op_q      <= op_d;
            op_done_q <= op_done_d;
        end
    end

    assign bus.acc       = acc_q;
    assign bus.carry     = carry_q;
    assign bus.op_code   = op_q;
    assign bus.op_done   = op_done_q;
    assign bus.pb_stable = stable_vec;

endmodule

// File: tb/tb_panel_command_unit.sv
// Scoreboard bench for panel_command_unit.
// Repeat scenario is included when PANEL_AUTOREPEAT_EN is defined.
module tb_panel_command_unit;
    import panel_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    panel_command_unit_if bus();

    panel_command_unit #(
        .DEBOUNCE_FRAMES(4),
        .REPEAT_FRAMES  (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [15:0] acc;
        logic        carry;
        logic [2:0]  op;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [4:0]  m_st;
    int          m_cnt[5];
    int          m_rcnt[2];
    logic [15:0] m_acc;
    logic        m_carry;
    logic [2:0]  m_op;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st    = '0;
        m_acc   = '0;
        m_carry = 1'b0;
        m_op    = 3'd0;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        for (int j = 0; j < 2; j++) m_rcnt[j] = 0;
        sb_q.delete();
    endtask

    task automatic model_frame(input logic [15:0] s, input logic [4:0] p);
        logic [4:0] old;
        logic [4:0] ev;
        exp_t       e;
        old = m_st;
        ev  = '0;
        for (int i = 0; i < 5; i++) begin
            if (p[i] == m_st[i]) m_cnt[i] = 0;
            else if (m_cnt[i] == 3) begin
                m_st[i]  = p[i];
                m_cnt[i] = 0;
                if (p[i]) ev[i] = 1'b1;
            end else m_cnt[i]++;
        end
`ifdef PANEL_AUTOREPEAT_EN
        for (int j = 0; j < 2; j++) begin
            if (!m_st[1+j]) m_rcnt[j] = 0;
            else if (old[1+j]) begin
                if (m_rcnt[j] == 15) begin
                    m_rcnt[j] = 0;
                    ev[1+j]   = 1'b1;
                end else m_rcnt[j]++;
            end
        end
`else
        if (old != 5'h1f) ev = ev;
`endif
        for (int i = 0; i < 5; i++) begin
            if (ev[i]) begin
                case (i)
                    0: begin m_acc = s; m_carry = 1'b0; m_op = 3'd1; end
                    1: begin
                        {m_carry, m_acc} = {1'b0, m_acc} + {1'b0, s};
                        m_op = 3'd2;
                    end
                    2: begin
                        m_carry = (s > m_acc);
                        m_acc   = m_acc - s;
                        m_op    = 3'd3;
                    end
                    3: begin m_acc = '0; m_carry = 1'b0; m_op = 3'd4; end
                    default: begin m_acc = -m_acc; m_op = 3'd5; end
                endcase
                e.acc   = m_acc;
                e.carry = m_carry;
                e.op    = m_op;
                sb_q.push_back(e);
                break;
            end
        end
    endtask

    task automatic frame(input logic [15:0] s, input logic [4:0] p);
        @(negedge clk);
        bus.frame_stb = 1'b1;
        bus.sw        = s;
        bus.pb        = p;
        model_frame(s, p);
        @(negedge clk);
        bus.frame_stb = 1'b0;
        repeat (19) @(negedge clk);
        chk("pb_stable", 32'(bus.pb_stable), 32'(m_st));
    endtask

    task automatic hold(input logic [15:0] s, input logic [4:0] p,
                        input int n);
        for (int k = 0; k < n; k++) frame(s, p);
    endtask

    task automatic press(input logic [4:0] p, input logic [15:0] s);
        hold(s, p, 4);
        hold(s, 5'b0, 4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_acc", 32'(bus.acc), 32'h0);
        chk("rst_carry", 32'(bus.carry), 32'h0);
        chk("rst_op", 32'(bus.op_code), 32'h0);
        chk("rst_done", 32'(bus.op_done), 32'h0);
        chk("rst_stable", 32'(bus.pb_stable), 32'h0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    exp_t got_e;
    always @(negedge clk) begin
        if (rst_n && bus.op_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexp_done", 32'h1, 32'h0);
            end else begin
                got_e = sb_q.pop_front();
                chk("acc", 32'(bus.acc), 32'(got_e.acc));
                chk("carry", 32'(bus.carry), 32'(got_e.carry));
                chk("op_code", 32'(bus.op_code), 32'(got_e.op));
            end
        end
    end

    initial begin
        bus.frame_stb = 1'b0;
        bus.sw        = '0;
        bus.pb        = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("init_acc", 32'(bus.acc), 32'h0);
        chk("init_done", 32'(bus.op_done), 32'h0);
        rst_n = 1'b1;

        hold(16'h1234, 5'b00001, 4);
        chk("t2_acc", 32'(bus.acc), 32'h1234);
        chk("t2_op", 32'(bus.op_code), 32'h1);
        hold(16'h1234, 5'b00001, 20);
        hold(16'h1234, 5'b00000, 4);

        do_reset();
        hold(16'h0000, 5'b00000, 10);

        hold(16'h0000, 5'b00010, 3);
        hold(16'h0000, 5'b00000, 1);
        hold(16'h0000, 5'b00010, 3);
        chk("t3_stable", 32'(bus.pb_stable[1]), 32'h0);
        hold(16'h0000, 5'b00000, 4);

        press(5'b00001, 16'hFFFF);
        press(5'b00010, 16'h0002);
        chk("t4_add_acc", 32'(bus.acc), 32'h0001);
        chk("t4_add_c", 32'(bus.carry), 32'h1);
        press(5'b00100, 16'h0003);
        chk("t4_sub_acc", 32'(bus.acc), 32'hFFFE);
        chk("t4_sub_c", 32'(bus.carry), 32'h1);
        press(5'b10000, 16'h0000);
        chk("t4_neg_acc", 32'(bus.acc), 32'h0002);
        chk("t4_neg_c", 32'(bus.carry), 32'h1);

        press(5'b01001, 16'h00AA);
        chk("t5_acc", 32'(bus.acc), 32'h00AA);
        chk("t5_op", 32'(bus.op_code), 32'h1);

`ifdef PANEL_AUTOREPEAT_EN
        press(5'b01000, 16'h0000);
        hold(16'h0001, 5'b00010, 54);
        chk("t6_acc4", 32'(bus.acc), 32'h0004);
        do_reset();
        hold(16'h0001, 5'b00010, 3);
        chk("t6_acc0", 32'(bus.acc), 32'h0000);
        hold(16'h0001, 5'b00010, 1);
        chk("t6_acc1", 32'(bus.acc), 32'h0001);
        hold(16'h0001, 5'b00000, 4);
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
